// File: rtl/logic_2048_nxn.sv
// SIZE x SIZE 2048 engine: one line per clock, valid/ready moves, board load port.
// Define SCORE_EN to add the saturating merge score output.
module logic_2048_nxn #(
    parameter int          SIZE        = 4,
    parameter int          NUM_WIDTH   = 4,
    parameter int          WIN_CODE    = 11,
    parameter int          SCREEN_HOLD = 1200,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          move_valid,
    input  logic [1:0]                    move_dir,
    output logic                          move_ready,
    input  logic                          load,
    input  logic [SIZE*SIZE*NUM_WIDTH-1:0] board_in,
    output logic [SIZE*SIZE*NUM_WIDTH-1:0] board_out,
    output logic [13:0]                   turns,
    output logic                          won,
    output logic                          lost,
    output logic                          busy
`ifdef SCORE_EN
    ,
    output logic [31:0]                   score
`endif
);
    localparam int N  = SIZE * SIZE;
    localparam int NW = NUM_WIDTH;
    localparam int LW = $clog2(SIZE);
    localparam int HW = $clog2(SCREEN_HOLD + 1);

    typedef logic [NW-1:0] cell_t;
    typedef enum logic [2:0] {IDLE, SLIDE, CHECK, SPAWN, HOLD} state_t;

    localparam cell_t MAX_CODE = '1;
    localparam cell_t WIN      = cell_t'(WIN_CODE);

    state_t          state_q, state_d;
    logic [N*NW-1:0] board_q, board_d;
    logic [13:0]     turns_q, turns_d;
    logic            won_q, won_d, lost_q, lost_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [LW-1:0]   line_q, line_d;
    logic [1:0]      dir_q, dir_d;
    logic            changed_q, changed_d;
    logic            loaded_q, loaded_d;
    logic            ready_q;
    logic [1:0]      over;
    cell_t           line_out [SIZE];
`ifdef SCORE_EN
    logic [31:0]     score_q, score_d;
    logic [40:0]     gain, sum;
`endif

    // Position j of line i, j = 0 being the cell on the move side.
    function automatic int cell_idx(input logic [1:0] d, input int i, input int j);
        case (d)
            2'd0:    return i * SIZE + j;
            2'd1:    return i * SIZE + (SIZE - 1 - j);
            2'd2:    return j * SIZE + i;
            default: return (SIZE - 1 - j) * SIZE + i;
        endcase
    endfunction

    // {won, lost} for a board
    function automatic logic [1:0] eval_over(input logic [N*NW-1:0] b);
        logic  w, empty, pair;
        cell_t v;
        w = 1'b0; empty = 1'b0; pair = 1'b0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                v = b[(r*SIZE+c)*NW +: NW];
                if (v >= WIN) w = 1'b1;
                if (v == '0) empty = 1'b1;
                if (c < SIZE - 1 && v == b[(r*SIZE+c+1)*NW +: NW]) pair = 1'b1;
                if (r < SIZE - 1 && v == b[((r+1)*SIZE+c)*NW +: NW]) pair = 1'b1;
            end
        end
        return {w, !empty && !pair};
    endfunction

    always_comb begin
        cell_t v;
        int    k, idx, start;
        logic  can, found;
        state_d   = state_q;
        board_d   = board_q;
        turns_d   = turns_q;
        won_d     = won_q;
        lost_d    = lost_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        hold_d    = hold_q;
        line_d    = line_q;
        dir_d     = dir_q;
        changed_d = changed_q;
        loaded_d  = loaded_q;
        over      = '0;
        v         = '0;
        k         = 0;
        idx       = 0;
        start     = 0;
        can       = 1'b0;
        found     = 1'b0;
        for (int j = 0; j < SIZE; j++) line_out[j] = '0;
`ifdef SCORE_EN
        score_d = score_q;
        gain    = '0;
        sum     = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    board_d   = board_in;
                    loaded_d  = 1'b1;
                    changed_d = 1'b0;
                    state_d   = CHECK;
                end else if (move_valid) begin
                    dir_d     = move_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    loaded_d  = 1'b0;
                    state_d   = SLIDE;
                end
            end
            SLIDE: begin
                // Compact toward j = 0; a freshly merged tile cannot merge again.
                for (int j = 0; j < SIZE; j++) begin
                    v = board_q[cell_idx(dir_q, int'(line_q), j)*NW +: NW];
                    if (v != '0) begin
                        if (can && line_out[k-1] == v && v != MAX_CODE) begin
                            line_out[k-1] = v + 1'b1;
                            can = 1'b0;
`ifdef SCORE_EN
                            if (int'(line_out[k-1]) >= 32) gain = gain + 41'h1_0000_0000;
                            else gain = gain + (41'd1 << line_out[k-1]);
`endif
                        end else begin
                            line_out[k] = v;
                            k = k + 1;
                            can = 1'b1;
                        end
                    end
                end
                for (int j = 0; j < SIZE; j++) begin
                    idx = cell_idx(dir_q, int'(line_q), j);
                    if (board_q[idx*NW +: NW] != line_out[j]) changed_d = 1'b1;
                    board_d[idx*NW +: NW] = line_out[j];
                end
`ifdef SCORE_EN
                sum     = {9'b0, score_q} + gain;
                score_d = (|sum[40:32]) ? '1 : sum[31:0];
`endif
                if (line_q == LW'(SIZE - 1)) begin
                    line_d  = '0;
                    state_d = CHECK;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
            CHECK: begin
                if (loaded_q) begin
                    over    = eval_over(board_q);
                    won_d   = over[1];
                    lost_d  = over[0];
                    hold_d  = '0;
                    state_d = (|over) ? HOLD : IDLE;
                end else if (changed_q) begin
                    if (turns_q != 14'h3FFF) turns_d = turns_q + 1'b1;
                    state_d = SPAWN;
                end else begin
                    state_d = IDLE;
                end
                loaded_d = 1'b0;
            end
            SPAWN: begin
                start = int'(lfsr_q[7:0]) % N;
                for (int s = 0; s < N; s++) begin
                    idx = (start + s) % N;
                    if (!found && board_q[idx*NW +: NW] == '0) begin
                        board_d[idx*NW +: NW] = cell_t'(1);
                        found = 1'b1;
                    end
                end
                over    = eval_over(board_d);
                won_d   = over[1];
                lost_d  = over[0];
                hold_d  = '0;
                state_d = (|over) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_q == HW'(SCREEN_HOLD - 1)) begin
                    board_d = '0;
                    turns_d = '0;
                    won_d   = 1'b0;
                    lost_d  = 1'b0;
                    hold_d  = '0;
`ifdef SCORE_EN
                    score_d = '0;
`endif
                    state_d = SPAWN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = SPAWN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SPAWN;
            board_q   <= '0;
            turns_q   <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            hold_q    <= '0;
            line_q    <= '0;
            dir_q     <= '0;
            changed_q <= 1'b0;
            loaded_q  <= 1'b0;
            ready_q   <= 1'b0;
`ifdef SCORE_EN
            score_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            turns_q   <= turns_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
            lfsr_q    <= lfsr_d;
            hold_q    <= hold_d;
            line_q    <= line_d;
            dir_q     <= dir_d;
            changed_q <= changed_d;
            loaded_q  <= loaded_d;
            ready_q   <= (state_d == IDLE);
`ifdef SCORE_EN
            score_q   <= score_d;
`endif
        end
    end

    assign move_ready = ready_q;
    assign busy       = ~ready_q;
    assign board_out  = board_q;
    assign turns      = turns_q;
    assign won        = won_q;
    assign lost       = lost_q;
`ifdef SCORE_EN
    assign score      = score_q;
`endif

endmodule

// File: tb/tb_logic_2048_nxn.sv
// Directed bench for logic_2048_nxn (SIZE=4, NUM_WIDTH=4, default parameters).
// Score checks are compiled in when SCORE_EN is defined.
module tb_logic_2048_nxn;
    localparam int SIZE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        load;
    logic [63:0] board_in;
    logic [63:0] board_out;
    logic [13:0] turns;
    logic        won;
    logic        lost;
    logic        busy;
`ifdef SCORE_EN
    logic [31:0] score;
    logic [31:0] score0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    logic [63:0] cb;

    always #5 clk = ~clk;

    logic_2048_nxn dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .load       (load),
        .board_in   (board_in),
        .board_out  (board_out),
        .turns      (turns),
        .won        (won),
        .lost       (lost),
        .busy       (busy)
`ifdef SCORE_EN
        ,
        .score      (score)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int count_nz(input logic [63:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (b[i*4 +: 4] != 4'd0) n++;
        return n;
    endfunction

    function automatic logic [63:0] checker_board();
        logic [63:0] b;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[(r*4+c)*4 +: 4] = ((r + c) % 2 == 0) ? 4'd1 : 4'd2;
        return b;
    endfunction

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!move_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!move_ready) chk("ready_timeout", {63'b0, move_ready}, 64'd1);
    endtask

    task automatic do_load(input logic [63:0] b);
        load     = 1'b1;
        board_in = b;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] d, output int n);
        move_valid = 1'b1;
        move_dir   = d;
        @(negedge clk);
        move_valid = 1'b0;
        wait_ready(20, n);
    endtask

    // Expected board plus exactly one spawned code-1 tile in a previously empty cell
    task automatic check_spawn(input string tag, input logic [63:0] exp);
        logic [63:0] e2;
        int pos;
        e2  = exp;
        pos = -1;
        for (int i = 0; i < 16; i++)
            if (pos < 0 && board_out[i*4 +: 4] != exp[i*4 +: 4]) pos = i;
        if (pos >= 0 && exp[pos*4 +: 4] == 4'd0) e2[pos*4 +: 4] = 4'd1;
        chk(tag, board_out, e2);
        chk({tag, "_tiles"}, 64'(count_nz(board_out)), 64'(count_nz(exp) + 1));
    endtask

    initial begin
        rst_n      = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        load       = 1'b0;
        board_in   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'b0, move_ready}, 64'd0);
        chk("rst_board", board_out, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_spawn", board_out, 64'h10);
        chk("rst_ready_up", {63'b0, move_ready}, 64'd1);
        chk("rst_turns", 64'(turns), 64'd0);
        chk("rst_flags", {62'b0, won, lost}, 64'd0);

        do_load(64'h2);
        wait_ready(10, cyc);
`ifdef SCORE_EN
        score0 = score;
`endif
        do_move(2'd0, cyc);
        chk("noop_lat", 64'(cyc), 64'd5);
        chk("noop_board", board_out, 64'h2);
        chk("noop_turns", 64'(turns), 64'd0);
`ifdef SCORE_EN
        chk("noop_score", 64'(score), 64'(score0));
`endif

        do_load(64'h111);
        wait_ready(10, cyc);
        do_move(2'd0, cyc);
        chk("left_lat", 64'(cyc), 64'd6);
        check_spawn("left_board", 64'h12);
        chk("left_turns", 64'(turns), 64'd1);

        do_load(64'h2233);
        wait_ready(10, cyc);
`ifdef SCORE_EN
        score0 = score;
`endif
        move_valid = 1'b1;
        move_dir   = 2'd1;
        @(negedge clk);
        repeat (SIZE) @(negedge clk);
        move_valid = 1'b0;
        wait_ready(20, cyc);
        chk("held_lat", 64'(cyc + SIZE), 64'd6);
        check_spawn("right_board", 64'h3400);
        chk("right_turns", 64'(turns), 64'd2);
`ifdef SCORE_EN
        chk("right_score", 64'(score - score0), 64'd24);
`endif

        cb = checker_board();
        cb[63:60] = 4'd0;
        do_load(cb);
        wait_ready(10, cyc);
        do_move(2'd1, cyc);
        cb[63:48] = 16'h2121;
        chk("chk_board", board_out, cb);
        chk("chk_flags", {62'b0, won, lost}, 64'd0);
        chk("chk_turns", 64'(turns), 64'd3);

        do_load(64'h111);
        wait_ready(10, cyc);
        move_valid = 1'b1;
        move_dir   = 2'd0;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_board", board_out, 64'd0);
        chk("mid_rst_turns", 64'(turns), 64'd0);
        chk("mid_rst_ready", {63'b0, move_ready}, 64'd0);
`ifdef SCORE_EN
        chk("mid_rst_score", 64'(score), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_spawn", board_out, 64'h10);
        chk("mid_rst_ready_up", {63'b0, move_ready}, 64'd1);

        do_load(checker_board());
        @(negedge clk);
        chk("lost_flags", {62'b0, won, lost}, 64'd1);
        chk("lost_ready", {63'b0, move_ready}, 64'd0);
        wait_ready(1300, cyc);
        chk("hold_len", 64'(cyc), 64'd1201);
        chk("lost_clear_tiles", 64'(count_nz(board_out)), 64'd1);
        chk("lost_clear_flags", {62'b0, won, lost}, 64'd0);

        do_load(64'hAA);
        wait_ready(10, cyc);
        move_valid = 1'b1;
        move_dir   = 2'd0;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("won_flags", {62'b0, won, lost}, 64'd2);
        chk("won_ready", {63'b0, move_ready}, 64'd0);
        check_spawn("won_board", 64'hB);
        chk("won_turns", 64'(turns), 64'd1);
        wait_ready(1300, cyc);
        chk("won_clear_turns", 64'(turns), 64'd0);
        chk("won_clear_flags", {62'b0, won, lost}, 64'd0);
        chk("won_clear_tiles", 64'(count_nz(board_out)), 64'd1);
        chk("won_clear_code", 64'(board_out != 64'd0 && count_nz(board_out) == 1
                                 && (board_out & 64'hEEEE_EEEE_EEEE_EEEE) == 64'd0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
